// File: rtl/read_issue_block.sv
// read_issue_block: issues Avalon-MM read bursts for a test run and pushes one
// compare descriptor per accepted burst. Bursts are only issued when both the
// compare descriptor FIFO and the read-data FIFO downstream have room.
module read_issue_block #(
  parameter int AMM_ADDR_W   = 28,
  parameter int AMM_BURST_W  = 7,
  parameter int CMP_CREDITS  = 4,
  parameter int DATA_CREDITS = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   test_start_i,
  input  logic [AMM_ADDR_W-1:0]  start_addr_i,
  input  logic [15:0]            total_words_i,
  input  logic [AMM_BURST_W-1:0] burst_len_i,
  input  logic [7:0]             data_ptrn_i,
  input  logic                   data_mode_i,
  output logic                   read_o,
  output logic [AMM_ADDR_W-1:0]  address_o,
  output logic [AMM_BURST_W-1:0] burstcount_o,
  input  logic                   waitrequest_i,
  input  logic                   readdatavalid_i,
  input  logic                   cmp_pop_i,
  output logic                   cmp_en_o,
  output logic [AMM_ADDR_W-1:0]  cmp_start_addr_o,
  output logic [AMM_BURST_W-2:0] cmp_words_count_o,
  output logic [7:0]             cmp_data_ptrn_o,
  output logic                   cmp_data_mode_o,
  output logic                   busy_o,
  output logic                   done_o
);

  // total_words_i + 1 can reach 65536, so one extra bit over the port width
  localparam int REM_W = 17;
  localparam int CR_W  = $clog2(CMP_CREDITS + 1);
  localparam int DIF_W = $clog2(DATA_CREDITS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REQ  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   read_q, read_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CR_W-1:0]        cr_q, cr_d;
  logic [DIF_W-1:0]       dif_q, dif_d;
  logic [AMM_ADDR_W-1:0]  addr_q, addr_d;
  logic [REM_W-1:0]       rem_q, rem_d;
  logic [AMM_BURST_W-1:0] blcfg_q, blcfg_d;
  logic [7:0]             ptrn_q, ptrn_d;
  logic                   mode_q, mode_d;

  logic [AMM_BURST_W-1:0] blen_req;
  logic [AMM_BURST_W-1:0] blen;
  logic [AMM_BURST_W-1:0] blen_m1;
  logic                   credit_ok;
  logic                   accept;
  logic                   restart;

  // Burst length from the latched command: at least 1, never past the run end
  always_comb begin
    blen_req = (blcfg_q == '0) ? AMM_BURST_W'(1) : blcfg_q;
    if (rem_q < REM_W'(blen_req)) begin
      blen = rem_q[AMM_BURST_W-1:0];
    end else begin
      blen = blen_req;
    end
    blen_m1 = blen - AMM_BURST_W'(1);
  end

  assign credit_ok = (cr_q != '0) &&
                     ((32'(dif_q) + 32'(blen)) <= 32'(DATA_CREDITS));
  // A restart in the same cycle wins over acceptance: the old run's burst is
  // abandoned and no descriptor is pushed for it.
  assign restart   = test_start_i && (state_q != S_IDLE);
  assign accept    = (state_q == S_REQ) && !waitrequest_i && !restart;

  assign read_o            = read_q;
  assign address_o         = addr_q;
  assign burstcount_o      = blen;
  assign cmp_en_o          = accept;
  assign cmp_start_addr_o  = addr_q;
  assign cmp_words_count_o = blen_m1[AMM_BURST_W-2:0];
  assign cmp_data_ptrn_o   = ptrn_q;
  assign cmp_data_mode_o   = mode_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;

  // Next-state, counters and credit bookkeeping
  always_comb begin
    state_d = state_q;
    read_d  = read_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    addr_d  = addr_q;
    rem_d   = rem_q;
    blcfg_d = blcfg_q;
    ptrn_d  = ptrn_q;
    mode_d  = mode_q;

    // Compare credits: net of push and pop, saturating at full
    cr_d = cr_q;
    if (accept && !cmp_pop_i) begin
      cr_d = cr_q - CR_W'(1);
    end else if (cmp_pop_i && !accept && (cr_q != CR_W'(CMP_CREDITS))) begin
      cr_d = cr_q + CR_W'(1);
    end

    // Words in flight: add the accepted burst, retire one per valid, no underflow
    dif_d = dif_q;
    if (accept) begin
      dif_d = dif_d + DIF_W'(blen);
    end
    if (readdatavalid_i && (dif_q != '0)) begin
      dif_d = dif_d - DIF_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        read_d = 1'b0;
        if (test_start_i) begin
          state_d = S_WAIT;
          busy_d  = 1'b1;
        end
      end
      S_WAIT: begin
        if (credit_ok) begin
          state_d = S_REQ;
          read_d  = 1'b1;
        end
      end
      S_REQ: begin
        if (!waitrequest_i) begin
          addr_d = addr_q + AMM_ADDR_W'(blen);
          rem_d  = rem_q - REM_W'(blen);
          read_d = 1'b0;
          if (rem_d == '0) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        read_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // A start pulse always relatches the command and begins a fresh run
    if (test_start_i) begin
      addr_d  = start_addr_i;
      rem_d   = REM_W'(total_words_i) + REM_W'(1);
      blcfg_d = burst_len_i;
      ptrn_d  = data_ptrn_i;
      mode_d  = data_mode_i;
    end
    if (restart) begin
      state_d = S_WAIT;
      read_d  = 1'b0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      cr_d    = CR_W'(CMP_CREDITS);
      dif_d   = '0;
    end
  end

  // Control state is reset; the command/address datapath is not
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cr_q    <= CR_W'(CMP_CREDITS);
      dif_q   <= '0;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cr_q    <= cr_d;
      dif_q   <= dif_d;
    end
    addr_q  <= addr_d;
    rem_q   <= rem_d;
    blcfg_q <= blcfg_d;
    ptrn_q  <= ptrn_d;
    mode_q  <= mode_d;
  end

endmodule

// File: tb/tb_read_issue_block.sv
// Directed testbench for read_issue_block.
module tb_read_issue_block;

  localparam int AW = 28;
  localparam int BW = 7;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i         = 1'b1;
  logic          test_start_i  = 1'b0;
  logic [AW-1:0] start_addr_i  = '0;
  logic [15:0]   total_words_i = '0;
  logic [BW-1:0] burst_len_i   = '0;
  logic [7:0]    data_ptrn_i   = '0;
  logic          data_mode_i   = 1'b0;
  logic          waitrequest_i = 1'b0;
  logic          readdatavalid_i;
  logic          cmp_pop_i;

  logic          read_o;
  logic [AW-1:0] address_o;
  logic [BW-1:0] burstcount_o;
  logic          cmp_en_o;
  logic [AW-1:0] cmp_start_addr_o;
  logic [BW-2:0] cmp_words_count_o;
  logic [7:0]    cmp_data_ptrn_o;
  logic          cmp_data_mode_o;
  logic          busy_o;
  logic          done_o;

  logic vld_auto = 1'b0, vld_man = 1'b0, pop_auto = 1'b0, pop_man = 1'b0;
  logic auto_pop = 1'b0, auto_valid = 1'b0;
  assign readdatavalid_i = vld_auto | vld_man;
  assign cmp_pop_i       = pop_auto | pop_man;

  read_issue_block dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .test_start_i      (test_start_i),
    .start_addr_i      (start_addr_i),
    .total_words_i     (total_words_i),
    .burst_len_i       (burst_len_i),
    .data_ptrn_i       (data_ptrn_i),
    .data_mode_i       (data_mode_i),
    .read_o            (read_o),
    .address_o         (address_o),
    .burstcount_o      (burstcount_o),
    .waitrequest_i     (waitrequest_i),
    .readdatavalid_i   (readdatavalid_i),
    .cmp_pop_i         (cmp_pop_i),
    .cmp_en_o          (cmp_en_o),
    .cmp_start_addr_o  (cmp_start_addr_o),
    .cmp_words_count_o (cmp_words_count_o),
    .cmp_data_ptrn_o   (cmp_data_ptrn_o),
    .cmp_data_mode_o   (cmp_data_mode_o),
    .busy_o            (busy_o),
    .done_o            (done_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Descriptor log captured on the falling edge
  logic [31:0] p_addr[64];
  logic [31:0] p_wc[64];
  logic [31:0] p_bc[64];
  logic [31:0] p_pm[64];
  int   n_push = 0, n_done = 0, n_rd = 0;
  logic pend_push = 1'b0;
  int   pend_bc = 0;
  int   owed = 0;
  int   owed_n;

  always @(negedge clk) begin
    if (cmp_en_o) begin
      p_addr[n_push % 64] <= 32'(cmp_start_addr_o);
      p_wc[n_push % 64]   <= 32'(cmp_words_count_o);
      p_bc[n_push % 64]   <= 32'(burstcount_o);
      p_pm[n_push % 64]   <= {23'd0, cmp_data_mode_o, cmp_data_ptrn_o};
      n_push <= n_push + 1;
    end
    if (done_o) n_done <= n_done + 1;
    if (read_o) n_rd <= n_rd + 1;
    pend_push <= cmp_en_o;
    pend_bc   <= int'(burstcount_o);
  end

  // Downstream stand-in: pop one cycle after each push, return the burst's words
  assign owed_n = owed + (pend_push ? pend_bc : 0);
  always @(posedge clk) begin
    pop_auto <= auto_pop && pend_push;
    if (auto_valid && owed_n > 0) begin
      vld_auto <= 1'b1;
      owed     <= owed_n - 1;
    end else begin
      vld_auto <= 1'b0;
      owed     <= auto_valid ? owed_n : 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(input logic [AW-1:0] a, input logic [15:0] tw, input logic [BW-1:0] bl);
    start_addr_i  = a;
    total_words_i = tw;
    burst_len_i   = bl;
    test_start_i  = 1'b1;
    cyc();
    test_start_i  = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    auto_pop   = 1'b0;
    auto_valid = 1'b0;
    rst_i      = 1'b1;
    cyc(2);
    check({tag, "_read"},  32'(read_o),   0);
    check({tag, "_cmpen"}, 32'(cmp_en_o), 0);
    check({tag, "_busy"},  32'(busy_o),   0);
    check({tag, "_done"},  32'(done_o),   0);
    rst_i = 1'b0;
    cyc(2);
  endtask

  task automatic wait_done(input int base, input int budget, input string tag);
    int k = 0;
    while (n_done == base && k < budget) begin
      cyc();
      k++;
    end
    check({tag, "_done_seen"}, 32'(n_done > base), 1);
  endtask

  task automatic wait_read(input int budget, input string tag);
    int k = 0;
    while (read_o !== 1'b1 && k < budget) begin
      cyc();
      k++;
    end
    check({tag, "_read_seen"}, 32'(read_o), 1);
  endtask

  initial begin
    int pb, d0, rb, k;
    logic [31:0] a0, b0;
    logic stable;

    // Reset state
    cyc(2);
    check("rst_read",  32'(read_o),   0);
    check("rst_cmpen", 32'(cmp_en_o), 0);
    check("rst_busy",  32'(busy_o),   0);
    check("rst_done",  32'(done_o),   0);
    rst_i = 1'b0;
    cyc(2);

    // 100 words in bursts of 32
    auto_pop = 1'b1; auto_valid = 1'b1; waitrequest_i = 1'b0;
    data_ptrn_i = 8'hA5; data_mode_i = 1'b1;
    pb = n_push; d0 = n_done;
    start_run(28'h100, 16'd99, 7'd32);
    check("t1_busy_after_start", 32'(busy_o), 1);
    wait_done(d0, 2000, "t1");
    check("t1_busy_end", 32'(busy_o), 0);
    check("t1_npush", 32'(n_push - pb), 4);
    check("t1_a0", p_addr[pb % 64],       32'h100);
    check("t1_a1", p_addr[(pb + 1) % 64], 32'h120);
    check("t1_a2", p_addr[(pb + 2) % 64], 32'h140);
    check("t1_a3", p_addr[(pb + 3) % 64], 32'h160);
    check("t1_wc0", p_wc[pb % 64],       31);
    check("t1_wc2", p_wc[(pb + 2) % 64], 31);
    check("t1_wc3", p_wc[(pb + 3) % 64], 3);
    check("t1_bc1", p_bc[(pb + 1) % 64], 32);
    check("t1_bc3", p_bc[(pb + 3) % 64], 4);
    check("t1_seed_mode", p_pm[(pb + 3) % 64], 32'h1A5);
    cyc(5);
    check("t1_ndone", 32'(n_done - d0), 1);

    // Stall the first burst for 5 cycles
    waitrequest_i = 1'b1;
    pb = n_push; d0 = n_done; rb = n_rd;
    start_run(28'h200, 16'd9, 7'd8);
    wait_read(10, "t2");
    a0 = 32'(address_o); b0 = 32'(burstcount_o);
    stable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (read_o !== 1'b1 || 32'(address_o) !== a0 || 32'(burstcount_o) !== b0) stable = 1'b0;
    end
    waitrequest_i = 1'b0;
    cyc();
    check("t2_stall_stable", 32'(stable), 1);
    check("t2_addr", a0, 32'h200);
    check("t2_bc", b0, 8);
    check("t2_read_dropped", 32'(read_o), 0);
    check("t2_read_cycles", 32'(n_rd - rb), 6);
    check("t2_one_push", 32'(n_push - pb), 1);
    wait_done(d0, 200, "t2");
    check("t2_a1", p_addr[(pb + 1) % 64], 32'h208);
    check("t2_wc1", p_wc[(pb + 1) % 64], 1);

    // No pops: compare credits run out after 4 bursts
    do_reset("r3");
    auto_valid = 1'b1;
    pb = n_push;
    start_run(28'h400, 16'd9, 7'd1);
    cyc(60);
    check("t3_npush_stall", 32'(n_push - pb), 4);
    check("t3_busy", 32'(busy_o), 1);
    check("t3_read_idle", 32'(read_o), 0);
    pop_man = 1'b1;
    cyc();
    pop_man = 1'b0;
    cyc(20);
    check("t3_npush_after_pop", 32'(n_push - pb), 5);
    check("t3_a4", p_addr[(pb + 4) % 64], 32'h404);
    check("t3_read_idle2", 32'(read_o), 0);

    // Reset mid-run, then data credit gating with 64-word bursts
    do_reset("r4");
    auto_pop = 1'b1;
    pb = n_push; d0 = n_done;
    start_run(28'h1000, 16'd127, 7'd64);
    cyc(40);
    check("t4_npush_1", 32'(n_push - pb), 1);
    vld_man = 1'b1;
    cyc();
    vld_man = 1'b0;
    cyc(10);
    check("t4_npush_after_1vld", 32'(n_push - pb), 1);
    vld_man = 1'b1;
    cyc(63);
    vld_man = 1'b0;
    cyc(10);
    check("t4_npush_after_64vld", 32'(n_push - pb), 2);
    check("t4_a1", p_addr[(pb + 1) % 64], 32'h1040);
    check("t4_wc1", p_wc[(pb + 1) % 64], 63);
    check("t4_ndone", 32'(n_done - d0), 1);

    // Address wrap at 2^28
    do_reset("r5");
    auto_pop = 1'b1; auto_valid = 1'b1;
    pb = n_push; d0 = n_done;
    start_run(28'hFFFFFF0, 16'd63, 7'd32);
    wait_done(d0, 500, "t5");
    check("t5_npush", 32'(n_push - pb), 2);
    check("t5_a0", p_addr[pb % 64], 32'hFFFFFF0);
    check("t5_a1_wrapped", p_addr[(pb + 1) % 64], 32'h10);
    check("t5_wc0", p_wc[pb % 64], 31);

    // Restart during a stalled burst, with compare credits partly used
    do_reset("r6");
    auto_valid = 1'b1;
    pb = n_push;
    start_run(28'h2000, 16'd7, 7'd2);
    k = 0;
    while ((n_push - pb) < 3 && k < 100) begin
      cyc();
      k++;
    end
    check("t6_three_pushes", 32'(n_push - pb), 3);
    waitrequest_i = 1'b1;
    wait_read(10, "t6");
    cyc(2);
    check("t6_stalled", 32'(read_o), 1);
    pb = n_push;
    waitrequest_i = 1'b0;
    start_run(28'h3000, 16'd19, 7'd4);
    check("t6_read_dropped", 32'(read_o), 0);
    check("t6_no_old_push", 32'(n_push - pb), 0);
    cyc(60);
    check("t6_npush_credits_restored", 32'(n_push - pb), 4);
    check("t6_a0", p_addr[pb % 64], 32'h3000);
    check("t6_wc0", p_wc[pb % 64], 3);
    check("t6_busy", 32'(busy_o), 1);
    rst_i = 1'b1;
    cyc();
    check("t6_rst_read",  32'(read_o),   0);
    check("t6_rst_cmpen", 32'(cmp_en_o), 0);
    check("t6_rst_busy",  32'(busy_o),   0);
    check("t6_rst_done",  32'(done_o),   0);
    rst_i = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
